float_point_divide_iter: RTL
============================

// Module: float_point_divide_iter
// PURPOSE
//  Iterative IEEE-754 single-precision divider, oZ = iA / iB; inverse partner of the pipelined float multiplier.
//  Restoring radix-2 mantissa division (one quotient bit per clk), then normalize/pack; one op in flight.
//  Shares the multiplier's iValid/oDone handshake so FP datapath control can issue to either unit.
// PARAMETERS
//  QBITS      27   quotient bits produced (24 mantissa + guard + round; fixed, not for override)
//  EXP_BIAS   127  IEEE single exponent bias
// PORTS
//  clk     in   1   clock, rising edge
//  resetn  in   1   reset, asynchronous, active-low
//  iValid  in   1   start request; sampled only in IDLE
//  iA      in   32  dividend, IEEE single
//  iB      in   32  divisor, IEEE single
//  oBusy   out  1   high from the edge after accept until the cycle oDone is asserted
//  oDone   out  1   one-cycle pulse, oZ valid
//  oZ      out  32  quotient; holds until next oDone
// BEHAVIOUR
//  Reset: oZ=0, oDone=0, oBusy=0, FSM=IDLE, all datapath regs 0. Reset mid-op aborts; no oDone follows.
//  FSM: IDLE -> DIV (iValid=1) ; DIV -> NORM (count==QBITS-1) ; NORM -> DONE ; DONE -> IDLE.
//  IDLE accept edge: sign=iA[31]^iB[31]; exp(10b signed)=iA[30:23]-iB[30:23]+127;
//   R(25b)={1,iA[22:0]}, D={1,iB[22:0]}, q=0, count=0; special-case flags latched.
//  DIV, each cycle: if R>=D {q={q[25:0],1}; R=(R-D)<<1} else {q={q[25:0],0}; R=R<<1}; count++.
//   27 cycles; q in (0.5,2) with q[26] weight 1.
//  NORM: q[26]=1 -> mant=q[26:3], g=q[2], s=|q[1:0]|(R!=0);
//        else     -> mant=q[25:2], g=q[1], s=q[0]|(R!=0), exp=exp-1.
//  DONE edge: oZ registered, oDone=1 for exactly this cycle, oBusy drops.
//  Latency: oDone high 29 clk edges after the edge that sampled iValid; fixed for all operands.
//  Throughput: 1 op / 30 cycles; iValid in DONE cycle ignored, accepted next cycle (IDLE).
//  iValid while oBusy=1: ignored, no queueing; iA/iB only need to be valid on the accept edge.
//  Special cases (priority order, still full 29-cycle latency):
//   1) iB exp==0 (zero/denormal divisor)          -> {sign,8'hFF,23'h0} (inf; 0/0 also inf)
//   2) iA exp==0 (zero/denormal dividend)         -> {sign,31'h0}
//   3) iA or iB exp==8'hFF (inf/NaN in)           -> {sign,8'hFF,23'h0}
//   4) final exp >= 255                           -> {sign,8'hFF,23'h0} overflow
//   5) final exp <= 0                             -> {sign,31'h0} underflow, flush to zero
//   else oZ={sign,exp[7:0],mant[22:0]}.
//  Denormals never produced nor interpreted; exp arithmetic is 10b signed, no wrap.
// CONFIGURATION
//  FPD_ROUND_EN defined: round-to-nearest-even in NORM: if g&(s|mant[0]) mant=mant+1;
//   carry out of mant -> mant=24'h800000, exp+1 (then overflow check 4 applies). Latency unchanged.
//  FPD_ROUND_EN undefined: truncate (g,s discarded), bit-compatible with multiplier truncation.
// TESTING
//  6.0/2.0: iA=0x40C00000 iB=0x40000000 -> oZ=0x40400000, oDone exactly 29 edges after accept.
//  1.0/3.0: 0x3F800000/0x40400000 -> 0x3EAAAAAA; with FPD_ROUND_EN -> 0x3EAAAAAB.
//  Sign/normalize: 0xBF800000/0x3F000000 (-1/0.5) -> 0xC0000000; 0x3F800000/0x3F800000 -> 0x3F800000.
//  Specials: x/0 0x3F800000/0x00000000 -> 0x7F800000; 0/x -> 0x00000000;
//   overflow 0x7F000000/0x00800000 -> 0x7F800000; underflow 0x00800000/0x7F000000 -> 0x00000000.
//  Busy: second iValid (different operands) 5 cycles after accept -> ignored, single oDone with first result.
//  Reset mid-op: resetn low 10 cycles after accept -> oZ=0,oDone=0,oBusy=0; no stray oDone;
//   fresh op after release completes correctly.

Source files
------------

// File: rtl/float_point_divide_iter.sv
// Iterative IEEE-754 single-precision divider: restoring radix-2, one quotient bit per clock.
// Optional round-to-nearest-even when FPD_ROUND_EN is defined; otherwise the quotient is truncated.
module float_point_divide_iter #(
  parameter int QBITS    = 27,
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iValid,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oZ
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_accept;
  logic                    w_div_en;
  logic                    w_norm_en;
  logic                    w_done_en;

  logic                    r_sign;
  logic signed [9:0]       r_exp;
  logic [24:0]             r_rem;
  logic [23:0]             r_div;
  logic [QBITS-1:0]        r_q;
  logic [4:0]              r_cnt;
  logic                    r_zero_div;
  logic                    r_zero_dvd;
  logic                    r_inf_in;
  logic [22:0]             r_frac;
  logic                    r_busy;
  logic                    r_done;
  logic [31:0]             r_z;

  logic signed [9:0]       w_exp0;
  logic                    w_ge;
  logic [23:0]             w_diff;
  logic [24:0]             w_rem_nxt;
  logic [22:0]             w_frac;
  logic signed [9:0]       w_exp_n;
  logic [31:0]             w_z;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (iValid) w_state_nxt = S_DIV;
      S_DIV:   if (r_cnt == 5'(QBITS-1)) w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from state
  always_comb begin
    w_accept  = 1'b0;
    w_div_en  = 1'b0;
    w_norm_en = 1'b0;
    w_done_en = 1'b0;
    case (r_state)
      S_IDLE:  w_accept  = iValid;
      S_DIV:   w_div_en  = 1'b1;
      S_NORM:  w_norm_en = 1'b1;
      S_DONE:  w_done_en = 1'b1;
      default: ;
    endcase
  end

  assign w_exp0 = $signed({2'b00, iA[30:23]}) - $signed({2'b00, iB[30:23]})
                + $signed(10'(EXP_BIAS));

  // Remainder never exceeds 2*D, so the difference fits in 24 bits when R >= D.
  assign w_ge      = (r_rem >= {1'b0, r_div});
  assign w_diff    = r_rem[23:0] - r_div;
  assign w_rem_nxt = w_ge ? {w_diff, 1'b0} : {r_rem[23:0], 1'b0};

`ifdef FPD_ROUND_EN
  logic w_g;
  logic w_s;
`endif

  // Normalize: quotient lies in (0.5, 2); the hidden bit is dropped from the stored fraction.
  always_comb begin
    w_frac  = '0;
    w_exp_n = r_exp;
`ifdef FPD_ROUND_EN
    w_g = 1'b0;
    w_s = 1'b0;
`endif
    if (r_q[QBITS-1]) begin
      w_frac = r_q[QBITS-2 -: 23];
`ifdef FPD_ROUND_EN
      w_g = r_q[2];
      w_s = (|r_q[1:0]) | (r_rem != '0);
`endif
    end else begin
      w_frac  = r_q[QBITS-3 -: 23];
      w_exp_n = r_exp - 10'sd1;
`ifdef FPD_ROUND_EN
      w_g = r_q[1];
      w_s = r_q[0] | (r_rem != '0);
`endif
    end
`ifdef FPD_ROUND_EN
    if (w_g & (w_s | w_frac[0])) begin
      if (&w_frac) begin
        w_frac  = '0;
        w_exp_n = w_exp_n + 10'sd1;
      end else begin
        w_frac = w_frac + 23'd1;
      end
    end
`endif
  end

  // Special-case resolution in priority order
  always_comb begin
    if (r_zero_div)             w_z = {r_sign, 8'hFF, 23'h0};
    else if (r_zero_dvd)        w_z = {r_sign, 31'h0};
    else if (r_inf_in)          w_z = {r_sign, 8'hFF, 23'h0};
    else if (r_exp >= 10'sd255) w_z = {r_sign, 8'hFF, 23'h0};
    else if (r_exp <= 10'sd0)   w_z = {r_sign, 31'h0};
    else                        w_z = {r_sign, r_exp[7:0], r_frac};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_zero_div <= 1'b0;
      r_zero_dvd <= 1'b0;
      r_inf_in   <= 1'b0;
      r_frac     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_z        <= '0;
    end else begin
      if (w_accept) begin
        r_sign     <= iA[31] ^ iB[31];
        r_exp      <= w_exp0;
        r_rem      <= {2'b01, iA[22:0]};
        r_div      <= {1'b1, iB[22:0]};
        r_q        <= '0;
        r_cnt      <= '0;
        r_zero_div <= (iB[30:23] == 8'h00);
        r_zero_dvd <= (iA[30:23] == 8'h00);
        r_inf_in   <= (iA[30:23] == 8'hFF) | (iB[30:23] == 8'hFF);
      end
      if (w_div_en) begin
        r_q   <= {r_q[QBITS-2:0], w_ge};
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_norm_en) begin
        r_frac <= w_frac;
        r_exp  <= w_exp_n;
      end
      if (w_done_en) r_z <= w_z;
      r_done <= w_done_en;
      if (w_accept)       r_busy <= 1'b1;
      else if (w_done_en) r_busy <= 1'b0;
    end
  end

  assign oBusy = r_busy;
  assign oDone = r_done;
  assign oZ    = r_z;

endmodule
